// File: rtl/hex_pkg.sv
// Shared types and constants for the 7-segment message scroller.
package hex_pkg;

  // Scroller control states
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCROLL = 2'd1,
    HOLD   = 2'd2
  } state_t;

  // Write-port field positions within wr_data
  localparam int unsigned WR_W         = 5;
  localparam int unsigned WR_BLANK_BIT = 4;
  localparam int unsigned WR_NIB_MSB   = 3;
  localparam int unsigned WR_NIB_LSB   = 0;

  // Number of physical displays
  localparam int unsigned NDISP = 8;

  // Active-low {g,f,e,d,c,b,a}; all segments off
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Active-low segment codes for hex digits 0..F
  localparam logic [6:0] SEG_CODE [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  // One message buffer entry
  typedef struct packed {
    logic       blank;
    logic [3:0] nibble;
  } hex_entry_t;

endpackage

// File: rtl/hex7seg_decode.sv
// Combinational {blank, nibble} to active-low 7-segment code.
module hex7seg_decode
  import hex_pkg::*;
(
  input  logic       blank_i,
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_c
);

  // Blank overrides the digit lookup
  always_comb begin
    seg_c = SEG_CODE[nibble_i];
    if (blank_i) seg_c = SEG_BLANK;
  end

endmodule

// File: rtl/hex_scroll_ctrl.sv
// Message buffer and right-to-left scroller driving eight 7-segment displays.
module hex_scroll_ctrl
  import hex_pkg::*;
#(
  parameter int unsigned CLK_HZ  = 50_000_000,
  parameter int unsigned STEP_MS = 250,
  parameter int unsigned DEPTH   = 16
) (
  input  logic            clk_clk,
  input  logic            reset_reset,
  input  logic            wr_valid,
  output logic            wr_ready,
  input  logic [WR_W-1:0] wr_data,
  input  logic            start,
  input  logic            pause,
  input  logic            stop,
  output logic            busy,
  output logic [6:0]      hex0_export,
  output logic [6:0]      hex1_export,
  output logic [6:0]      hex2_export,
  output logic [6:0]      hex3_export,
  output logic [6:0]      hex4_export,
  output logic [6:0]      hex5_export,
  output logic [6:0]      hex6_export,
  output logic [6:0]      hex7_export
);

  localparam int unsigned STEP_CYCLES = CLK_HZ / 1000 * STEP_MS;
  localparam int unsigned AW          = $clog2(DEPTH);
  localparam int unsigned CW          = AW + 1;
  localparam int unsigned TW          = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;

  state_t          state_q, state_d;
  logic [CW-1:0]   count_q, count_d;
  logic [CW-1:0]   offset_q, offset_d;
  logic [CW-1:0]   offset_inc_c;
  logic [TW-1:0]   tick_q, tick_d;
  logic            wr_ready_q, wr_ready_d;
  logic            busy_q, busy_d;
  logic [6:0]      hex_q [NDISP];
  logic [6:0]      hex_d [NDISP];
  logic [6:0]      disp_seg_c [NDISP];

  hex_entry_t      msg_q [DEPTH];
  logic            msg_we;
  logic [AW-1:0]   msg_waddr;
  hex_entry_t      msg_wdata;

  // Control: buffer writes, state transitions, tick and offset stepping
  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    offset_d     = offset_q;
    tick_d       = tick_q;
    msg_we       = 1'b0;
    msg_waddr    = count_q[AW-1:0];
    msg_wdata.blank  = wr_data[WR_BLANK_BIT];
    msg_wdata.nibble = wr_data[WR_NIB_MSB:WR_NIB_LSB];
    offset_inc_c = offset_q + CW'(1);

    if (stop) begin
      state_d  = IDLE;
      count_d  = '0;
      offset_d = '0;
      tick_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (wr_valid && wr_ready_q) begin
            msg_we  = 1'b1;
            count_d = count_q + CW'(1);
          end
          // start sees the count including a same-cycle write
          if (start && (count_d != '0)) begin
            state_d  = SCROLL;
            offset_d = '0;
            tick_d   = '0;
          end
        end
        SCROLL: begin
          if (pause) begin
            state_d = HOLD;
          end else if (tick_q == TW'(STEP_CYCLES - 1)) begin
            tick_d = '0;
            if (count_q > CW'(NDISP)) begin
              offset_d = (offset_inc_c == count_q) ? '0 : offset_inc_c;
            end
          end else begin
            tick_d = tick_q + TW'(1);
          end
        end
        HOLD: begin
          if (!pause) state_d = SCROLL;
        end
        default: state_d = IDLE;
      endcase
    end

    wr_ready_d = (state_d == IDLE) && (count_d < CW'(DEPTH));
    busy_d     = (state_d != IDLE);
  end

  // Eight read ports: window position p = 7-k feeds display k
  for (genvar k = 0; k < NDISP; k++) begin : g_disp
    localparam int unsigned P = NDISP - 1 - k;
    logic [CW-1:0] sum_c;
    logic [AW-1:0] idx_c;
    hex_entry_t    entry_c;
    logic [6:0]    seg_c;

    // Wrap the window index with a single compare-and-subtract
    always_comb begin
      sum_c = offset_q + CW'(P);
      idx_c = AW'((sum_c >= count_q) ? (sum_c - count_q) : sum_c);
      entry_c.blank  = 1'b1;
      entry_c.nibble = 4'h0;
      if (count_q > CW'(NDISP)) begin
        entry_c = msg_q[idx_c];
      end else if (CW'(P) < count_q) begin
        entry_c = msg_q[AW'(P)];
      end
    end

    hex7seg_decode u_dec (
      .blank_i  (entry_c.blank),
      .nibble_i (entry_c.nibble),
      .seg_c    (seg_c)
    );

    assign disp_seg_c[k] = seg_c;
  end

  // Display update: blank on stop, track window while active, hold in IDLE
  always_comb begin
    for (int k = 0; k < NDISP; k++) begin
      hex_d[k] = hex_q[k];
      if (stop) begin
        hex_d[k] = SEG_BLANK;
      end else if (state_q != IDLE) begin
        hex_d[k] = disp_seg_c[k];
      end
    end
  end

  // Control and output registers
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      state_q    <= IDLE;
      count_q    <= '0;
      offset_q   <= '0;
      tick_q     <= '0;
      wr_ready_q <= 1'b1;
      busy_q     <= 1'b0;
      for (int k = 0; k < NDISP; k++) hex_q[k] <= SEG_BLANK;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      offset_q   <= offset_d;
      tick_q     <= tick_d;
      wr_ready_q <= wr_ready_d;
      busy_q     <= busy_d;
      for (int k = 0; k < NDISP; k++) hex_q[k] <= hex_d[k];
    end
  end

  // Message buffer; contents are meaningless while count is zero
  always_ff @(posedge clk_clk) begin
    if (msg_we) msg_q[msg_waddr] <= msg_wdata;
  end

  assign wr_ready    = wr_ready_q;
  assign busy        = busy_q;
  assign hex0_export = hex_q[0];
  assign hex1_export = hex_q[1];
  assign hex2_export = hex_q[2];
  assign hex3_export = hex_q[3];
  assign hex4_export = hex_q[4];
  assign hex5_export = hex_q[5];
  assign hex6_export = hex_q[6];
  assign hex7_export = hex_q[7];

endmodule

// File: tb/tb_hex_scroll_ctrl.sv
// Directed bench for hex_scroll_ctrl with a 4-cycle scroll step.
module tb_hex_scroll_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_valid;
  logic       wr_ready;
  logic [4:0] wr_data;
  logic       start;
  logic       pause;
  logic       stop;
  logic       busy;
  logic [6:0] hex0, hex1, hex2, hex3, hex4, hex5, hex6, hex7;
  logic [6:0] hex_w [8];

  int checks = 0;
  int errors = 0;

  // Expected windows, element k is display hex k (hex7 leftmost)
  localparam logic [6:0] W_BLANK [8] = '{7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F};
  localparam logic [6:0] W_012   [8] = '{7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h24, 7'h79, 7'h40};
  localparam logic [6:0] W_OFF0  [8] = '{7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40};
  localparam logic [6:0] W_OFF1  [8] = '{7'h00, 7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79};
  localparam logic [6:0] W_OFF9  [8] = '{7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40, 7'h10};
  localparam logic [6:0] W_16_15 [8] = '{7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40, 7'h0E};
  localparam logic [6:0] W_BB    [8] = '{7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h03, 7'h7F};

  always #5 clk = ~clk;

  assign hex_w[0] = hex0;
  assign hex_w[1] = hex1;
  assign hex_w[2] = hex2;
  assign hex_w[3] = hex3;
  assign hex_w[4] = hex4;
  assign hex_w[5] = hex5;
  assign hex_w[6] = hex6;
  assign hex_w[7] = hex7;

  hex_scroll_ctrl #(
    .CLK_HZ  (1000),
    .STEP_MS (4),
    .DEPTH   (16)
  ) dut (
    .clk_clk     (clk),
    .reset_reset (rst),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .wr_data     (wr_data),
    .start       (start),
    .pause       (pause),
    .stop        (stop),
    .busy        (busy),
    .hex0_export (hex0),
    .hex1_export (hex1),
    .hex2_export (hex2),
    .hex3_export (hex3),
    .hex4_export (hex4),
    .hex5_export (hex5),
    .hex6_export (hex6),
    .hex7_export (hex7)
  );

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic write_word(input logic [4:0] d);
    wr_valid = 1'b1;
    wr_data  = d;
    step(1);
    wr_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    step(1);
    stop = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (hex_w[k] !== W_BLANK[k]) begin
        errors++;
        $display("FAIL reset hex%0d got %h expected %h", k, hex_w[k], W_BLANK[k]);
      end
    end
    checks++;
    if (wr_ready !== 1'b1) begin errors++; $display("FAIL reset wr_ready got %b expected 1", wr_ready); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset busy got %b expected 0", busy); end
  endtask

  task automatic test_static();
    for (int i = 0; i < 3; i++) write_word(5'(i));
    pulse_start();
    checks++;
    if (busy !== 1'b1 || wr_ready !== 1'b0) begin
      errors++;
      $display("FAIL static_flags busy %b wr_ready %b expected 1 0", busy, wr_ready);
    end
    step(1);
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (hex_w[k] !== W_012[k]) begin
        errors++;
        $display("FAIL static_first hex%0d got %h expected %h", k, hex_w[k], W_012[k]);
      end
    end
    step(20);
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (hex_w[k] !== W_012[k]) begin
        errors++;
        $display("FAIL static_hold hex%0d got %h expected %h", k, hex_w[k], W_012[k]);
      end
    end
    pulse_stop();
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (hex_w[k] !== W_BLANK[k]) begin
        errors++;
        $display("FAIL static_stop hex%0d got %h expected %h", k, hex_w[k], W_BLANK[k]);
      end
    end
    checks++;
    if (busy !== 1'b0 || wr_ready !== 1'b1) begin
      errors++;
      $display("FAIL static_stop_flags busy %b wr_ready %b expected 0 1", busy, wr_ready);
    end
  endtask

  task automatic test_scroll();
    for (int i = 0; i < 10; i++) write_word(5'(i));
    pulse_start();
    step(1);
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (hex_w[k] !== W_OFF0[k]) begin
        errors++;
        $display("FAIL scroll_off0 hex%0d got %h expected %h", k, hex_w[k], W_OFF0[k]);
      end
    end
    step(3);
    checks++;
    if (hex0 !== 7'h78) begin errors++; $display("FAIL scroll_latency hex0 got %h expected 78", hex0); end
    step(1);
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (hex_w[k] !== W_OFF1[k]) begin
        errors++;
        $display("FAIL scroll_off1 hex%0d got %h expected %h", k, hex_w[k], W_OFF1[k]);
      end
    end
    step(32);
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (hex_w[k] !== W_OFF9[k]) begin
        errors++;
        $display("FAIL scroll_off9 hex%0d got %h expected %h", k, hex_w[k], W_OFF9[k]);
      end
    end
    step(4);
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (hex_w[k] !== W_OFF0[k]) begin
        errors++;
        $display("FAIL scroll_wrap hex%0d got %h expected %h", k, hex_w[k], W_OFF0[k]);
      end
    end
    pulse_stop();
  endtask

  task automatic test_pause();
    for (int i = 0; i < 10; i++) write_word(5'(i));
    pulse_start();
    step(1);
    pause = 1'b1;
    step(9);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL pause_busy got %b expected 1", busy); end
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (hex_w[k] !== W_OFF0[k]) begin
        errors++;
        $display("FAIL pause_frozen hex%0d got %h expected %h", k, hex_w[k], W_OFF0[k]);
      end
    end
    pause = 1'b0;
    step(4);
    checks++;
    if (hex0 !== 7'h78) begin errors++; $display("FAIL pause_early hex0 got %h expected 78", hex0); end
    step(1);
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (hex_w[k] !== W_OFF1[k]) begin
        errors++;
        $display("FAIL pause_resume hex%0d got %h expected %h", k, hex_w[k], W_OFF1[k]);
      end
    end
  endtask

  task automatic test_reset_mid();
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (hex_w[k] !== W_BLANK[k]) begin
        errors++;
        $display("FAIL midreset hex%0d got %h expected %h", k, hex_w[k], W_BLANK[k]);
      end
    end
    checks++;
    if (busy !== 1'b0 || wr_ready !== 1'b1) begin
      errors++;
      $display("FAIL midreset_flags busy %b wr_ready %b expected 0 1", busy, wr_ready);
    end
    pulse_start();
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL empty_start busy got %b expected 0", busy); end
    step(1);
    checks++;
    if (hex7 !== 7'h7F) begin errors++; $display("FAIL empty_start hex7 got %h expected 7f", hex7); end
  endtask

  task automatic test_full();
    for (int i = 0; i < 16; i++) write_word(5'(i));
    checks++;
    if (wr_ready !== 1'b0) begin errors++; $display("FAIL full_ready got %b expected 0", wr_ready); end
    wr_valid = 1'b1;
    wr_data  = 5'h0F;
    step(2);
    checks++;
    if (wr_ready !== 1'b0) begin errors++; $display("FAIL full_held got %b expected 0", wr_ready); end
    wr_valid = 1'b0;
    start = 1'b1;
    stop  = 1'b1;
    step(1);
    start = 1'b0;
    stop  = 1'b0;
    checks++;
    if (busy !== 1'b0 || wr_ready !== 1'b1) begin
      errors++;
      $display("FAIL start_stop_flags busy %b wr_ready %b expected 0 1", busy, wr_ready);
    end
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (hex_w[k] !== W_BLANK[k]) begin
        errors++;
        $display("FAIL start_stop hex%0d got %h expected %h", k, hex_w[k], W_BLANK[k]);
      end
    end
    pulse_start();
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL start_stop_cleared busy got %b expected 0", busy); end
    // Refill, overfill attempt, then confirm the scroll wraps at 16
    for (int i = 0; i < 16; i++) write_word(5'(i));
    write_word(5'h0A);
    pulse_start();
    step(1);
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (hex_w[k] !== W_OFF0[k]) begin
        errors++;
        $display("FAIL full_off0 hex%0d got %h expected %h", k, hex_w[k], W_OFF0[k]);
      end
    end
    step(60);
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (hex_w[k] !== W_16_15[k]) begin
        errors++;
        $display("FAIL full_off15 hex%0d got %h expected %h", k, hex_w[k], W_16_15[k]);
      end
    end
    pulse_stop();
  endtask

  task automatic test_back_to_back();
    write_word(5'h10);
    wr_valid = 1'b1;
    wr_data  = 5'h0B;
    start    = 1'b1;
    step(1);
    wr_valid = 1'b0;
    start    = 1'b0;
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL b2b_busy got %b expected 1", busy); end
    step(1);
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (hex_w[k] !== W_BB[k]) begin
        errors++;
        $display("FAIL b2b hex%0d got %h expected %h", k, hex_w[k], W_BB[k]);
      end
    end
    pulse_stop();
    // Write in a stop cycle must be dropped
    stop     = 1'b1;
    wr_valid = 1'b1;
    wr_data  = 5'h05;
    step(1);
    stop     = 1'b0;
    wr_valid = 1'b0;
    pulse_start();
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL stop_drops_write busy got %b expected 0", busy); end
  endtask

  initial begin
    rst      = 1'b1;
    wr_valid = 1'b0;
    wr_data  = 5'h00;
    start    = 1'b0;
    pause    = 1'b0;
    stop     = 1'b0;
    test_reset();
    test_static();
    test_scroll();
    test_pause();
    test_reset_mid();
    test_full();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
